ucp_param: RTL
==============

# ucp_param

Parametrised multicycle processing unit, the next generation of the fixed 4-bit (a+b)/2 CPU. It fetches instructions from an external program memory and executes them on three registers (X, Y, Z) through an internal ULA. The ULA supports add, subtract and average, and reports carry and zero flags. A start/halt controller replaces the free-running modulo-6 counter.

## Interface
Parameters:
- WIDTH, 4: data width of X, Y, Z, immediate and ULA.
- PROG_LEN, 6: number of program words. The PC wraps to 0 after word PROG_LEN-1.
- PC_W, 4: PC width. Requires PROG_LEN <= 2**PC_W.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin or restart execution. Honoured only in IDLE or HALT.
- instr  in  3+WIDTH  program word {opcode[2:0], imm[WIDTH-1:0]}. Valid combinationally for the current pc.
- pc  out  PC_W  program counter (address to program memory).
- opcode  out  3  opcode field of the instruction register (IR).
- outx  out  WIDTH  register X.
- outy  out  WIDTH  register Y (accumulator).
- out  out  WIDTH  register Z (result output).
- carry  out  1  carry/borrow flag.
- zero  out  1  zero flag.
- busy  out  1  high in FETCH and EXEC.
- halted  out  1  high in HALT.

## Operation
FSM states are IDLE, FETCH, EXEC, HALT.
- IDLE: waits for start, then goes to FETCH.
- FETCH: IR <= instr at the end of the cycle, then goes to EXEC.
- EXEC: executes IR, updates pc, then goes to FETCH. HLT goes to HALT instead.
- HALT: start sets pc <= 0 and goes to FETCH. X, Y, Z and flags are retained.
- start in FETCH or EXEC is ignored.

Opcodes (sum/difference computed at WIDTH+1 bits):
- 000 NOP: no register change.
- 001 LDX: X <= imm.
- 010 LDY: Y <= imm.
- 011 ADD: {carry, Y} <= X + Y.
- 100 SUB: Y <= Y - X (mod 2**WIDTH). carry <= 1 when X > Y (borrow).
- 101 AVG: Y <= (X + Y) >> 1, taking bits [WIDTH:1] of the full sum, so it never overflows. carry <= 0.
- 110 STZ: Z <= Y.
- 111 HLT: stop. pc is not advanced.

Flag rules:
- zero <= (new Y == 0) on ADD, SUB and AVG only.
- LDX, LDY, STZ, NOP and HLT leave carry and zero unchanged.

PC rules:
- In EXEC, pc <= (pc == PROG_LEN-1) ? 0 : pc + 1, for every opcode except HLT.
- A program without HLT loops forever.

## Timing
- Reset values: pc = 0, IR = 0 (opcode = 000), outx = outy = out = 0, carry = 0, zero = 0, busy = 0, halted = 0, state IDLE.
- rst takes priority over start and over any state. A reset mid-FETCH or mid-EXEC discards the instruction, and no register is written on that edge.
- Every instruction takes exactly 2 cycles.
- Start latency: start sampled at edge N puts the FSM in FETCH during cycle N+1.
- Write timing: a register written by the instruction fetched at pc=k is visible one cycle after its EXEC edge. This is 2 cycles per instruction after the FETCH.
- halted asserts the cycle after the HLT EXEC edge. busy deasserts in the same cycle.
- The program memory must present instr combinationally from pc within the FETCH cycle. pc changes only on EXEC edges and on start in HALT.

## Configuration
- UCP_AVG_ROUND_EN defined: AVG computes (X + Y + 1) >> 1 at WIDTH+1 bits, i.e. rounds half up. carry <= 0.
- UCP_AVG_ROUND_EN undefined: AVG truncates, (X + Y) >> 1.
- All other behaviour is identical in both builds.

## Test plan
- WIDTH=4, program LDX 7, LDY 9, AVG, STZ, HLT; start pulsed once -> out = 8, carry = 0, zero = 0, halted = 1 exactly 10 cycles after start sampled, pc = 4.
- LDX 7, LDY 8, AVG, STZ, HLT -> out = 7 without UCP_AVG_ROUND_EN, out = 8 with it.
- LDX 9, LDY 9, ADD, HLT -> outy = 2, carry = 1, zero = 0. Then LDX 3, LDY 3, SUB -> outy = 0, zero = 1, carry = 0. Then LDX 5, LDY 2, SUB -> outy = 13, carry = 1.
- PROG_LEN=6, program of NOPs only -> pc sequence 0,1,2,3,4,5,0 advancing every 2 cycles, halted stays 0, busy stays 1.
- rst asserted during the EXEC of an ADD with X = 9, Y = 9 -> next cycle all outputs at reset values, outy = 0 and not 2, state IDLE. start pulsed during FETCH has no effect.
- After HALT, pulse start -> pc = 0, FSM in FETCH next cycle, X, Y, Z and flags unchanged until the first writing instruction executes.

Source files
------------

// File: rtl/ucp_param.sv
// ucp_param: parametrised multicycle processing unit.
// Fetches {opcode, imm} words from an external program memory and executes
// them on registers X, Y (accumulator) and Z through an add/sub/avg unit.
// Every instruction takes a FETCH cycle followed by an EXEC cycle.
// Optional build macro UCP_AVG_ROUND_EN: AVG rounds half up instead of truncating.
module ucp_param #(
  parameter int WIDTH    = 4,
  parameter int PROG_LEN = 6,
  parameter int PC_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH+2:0] instr,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       opcode,
  output logic [WIDTH-1:0] outx,
  output logic [WIDTH-1:0] outy,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDX = 3'b001;
  localparam logic [2:0] OP_LDY = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AVG = 3'b101;
  localparam logic [2:0] OP_STZ = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  state_t            state_r, state_s;
  logic [PC_W-1:0]   pc_r, pc_s, pc_inc_s;
  logic [WIDTH+2:0]  ir_r, ir_s;
  logic [WIDTH-1:0]  x_r, x_s, y_r, y_s, z_r, z_s;
  logic              carry_r, carry_s, zero_r, zero_s;
  logic              busy_r, busy_s, halted_r, halted_s;

  logic [2:0]        ir_op_s;
  logic [WIDTH-1:0]  imm_s;
  logic [WIDTH:0]    sum_s, diff_s, avg_sum_s;

  assign ir_op_s = ir_r[WIDTH+2:WIDTH];
  assign imm_s   = ir_r[WIDTH-1:0];

  // Arithmetic unit: full-width sum and difference, the extra bit is carry/borrow.
  always_comb begin
    sum_s  = {1'b0, x_r} + {1'b0, y_r};
    diff_s = {1'b0, y_r} - {1'b0, x_r};
`ifdef UCP_AVG_ROUND_EN
    avg_sum_s = sum_s + {{WIDTH{1'b0}}, 1'b1};
`else
    avg_sum_s = sum_s;
`endif
    if (pc_r == PC_W'(PROG_LEN - 1)) begin
      pc_inc_s = {PC_W{1'b0}};
    end else begin
      pc_inc_s = pc_r + PC_W'(1);
    end
  end

  // Next-state and datapath update: everything holds unless the current state changes it.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    x_s     = x_r;
    y_s     = y_r;
    z_s     = z_r;
    carry_s = carry_r;
    zero_s  = zero_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        ir_s    = instr;
        state_s = S_EXEC;
      end
      S_EXEC: begin
        state_s = S_FETCH;
        pc_s    = pc_inc_s;
        case (ir_op_s)
          OP_NOP: x_s = x_r;
          OP_LDX: x_s = imm_s;
          OP_LDY: y_s = imm_s;
          OP_ADD: begin
            {carry_s, y_s} = sum_s;
            zero_s = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
          end
          OP_SUB: begin
            y_s     = diff_s[WIDTH-1:0];
            carry_s = diff_s[WIDTH];
            zero_s  = (diff_s[WIDTH-1:0] == {WIDTH{1'b0}});
          end
          OP_AVG: begin
            y_s     = avg_sum_s[WIDTH:1];
            carry_s = 1'b0;
            zero_s  = (avg_sum_s[WIDTH:1] == {WIDTH{1'b0}});
          end
          OP_STZ: z_s = y_r;
          OP_HLT: begin
            state_s = S_HALT;
            pc_s    = pc_r;
          end
          default: state_s = S_FETCH;
        endcase
      end
      S_HALT: begin
        if (start) begin
          pc_s    = {PC_W{1'b0}};
          state_s = S_FETCH;
        end else begin
          state_s = S_HALT;
        end
      end
      default: state_s = S_IDLE;
    endcase
    busy_s   = (state_s == S_FETCH) || (state_s == S_EXEC);
    halted_s = (state_s == S_HALT);
  end

  // State and datapath registers; reset wins over every state and discards the in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      pc_r     <= {PC_W{1'b0}};
      ir_r     <= {(WIDTH+3){1'b0}};
      x_r      <= {WIDTH{1'b0}};
      y_r      <= {WIDTH{1'b0}};
      z_r      <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      zero_r   <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      ir_r     <= ir_s;
      x_r      <= x_s;
      y_r      <= y_s;
      z_r      <= z_s;
      carry_r  <= carry_s;
      zero_r   <= zero_s;
      busy_r   <= busy_s;
      halted_r <= halted_s;
    end
  end

  assign pc     = pc_r;
  assign opcode = ir_op_s;
  assign outx   = x_r;
  assign outy   = y_r;
  assign out    = z_r;
  assign carry  = carry_r;
  assign zero   = zero_r;
  assign busy   = busy_r;
  assign halted = halted_r;

endmodule
